johnson_step_ctrl: RTL and testbench
====================================

Name: johnson_step_ctrl

Overview:
- Sequencer for the team's 4-stage twisted-ring (Johnson) counter datapath; a controller in front of the raw ring.
- Runs a requested number of steps in either direction, then reports completion with a start/busy/done handshake.
- Decodes the ring into a one-hot phase vector for downstream timing logic.
- Detects illegal ring codes and recovers to the all-zero state.

Parameters:
- WIDTH, 4, ring stages; the sequence has 2*WIDTH legal states.
- STEP_W, 8, width of the step-count request and internal remaining counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request a run; sampled only in IDLE.
- dir  in  1  0 = up, 1 = down; latched with start.
- steps  in  STEP_W  number of ring advances; latched with start.
- hold  in  1  freezes advancing while in RUN.
- load  in  1  load ring from load_val; honoured only in IDLE.
- load_val  in  WIDTH  value for load.
- q  out  WIDTH  ring state.
- phase  out  2*WIDTH  one-hot phase index of q.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  sticky illegal-code flag.

Behaviour:
- Reset (clr=1, async): q=0, state=IDLE, remaining=0, busy=0, done=0, err=0, phase=0...01.
- Up step, WIDTH=4: q_next = {~q[0], q[W-1:1]}. Sequence is 0000,1000,1100,1110,1111,0111,0011,0001, then 0000 again.
- Down step: q_next = {q[W-2:0], ~q[W-1]}; this is the exact reverse of the up sequence.
- Phase index:
  - q[0]=0: index = popcount(q).
  - q[0]=1: index = 2*WIDTH - popcount(q).
  - phase = 1 << index; purely combinational from q. Example: 1111 gives index 4; 0001 gives index 7.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - load=1 has priority over start. If load_val is legal, q takes load_val. If illegal, q takes 0 and err is set to 1. start is ignored in that cycle.
  - start=1 with steps!=0: latch dir, remaining=steps, go to RUN.
  - start=1 with steps==0: go directly to DONE; q is unchanged.
- RUN:
  - busy=1.
  - Each edge with hold=0: q advances one step in the latched direction and remaining decrements.
  - The edge on which remaining==1 advances q and moves to DONE.
  - hold=1: q and remaining are frozen.
  - start, dir, steps, load and load_val are ignored throughout RUN.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge E with steps=N (N>0) and no hold. q advances at edges E+1 through E+N. busy is high from E to E+N. done is high from E+N to E+N+1.
- Illegal-state guard:
  - If q ever holds a non-Johnson code in any state, the next edge forces q=0 and sets err. RUN continues counting from 0.
  - err clears only on clr.
- Wrap: up from 0001 goes to 0000; down from 0000 goes to 0001. No terminal-count stop other than remaining.
- clr asserted mid-RUN aborts immediately to the reset values; no done pulse is produced.

Optional Feature:
- Macro: JOHNSON_WRAP_CNT_EN.
- With the macro defined:
  - Adds output wraps[7:0]: counts RUN-state advances that land on q=0 (either direction).
  - Saturates at 255.
  - Cleared by clr and at each accepted start.
- Without the macro: the port is absent, with no logic and no behaviour change.

Test Plan:
- clr pulse mid-simulation -> q=0000, phase=00000001, busy=0, done=0, err=0 asynchronously, before the next edge.
- q=0000, start, dir=0, steps=8 -> q walks 1000,1100,1110,1111,0111,0011,0001,0000; phase goes 0x02 to 0x80 then 0x01; busy for 8 cycles; single done pulse.
- q=0000, start, dir=1, steps=3 -> q goes 0001,0011,0111; final phase=0x20; done one cycle after the third advance.
- Illegal load: IDLE, load=1, load_val=0101 -> next cycle q=0000, err=1. Then legal load 1100 -> q=1100 and err stays 1.
- Hold and ignored start: start steps=4 up from 0000, hold=1 for 2 cycles after the first advance, start re-pulsed during RUN -> q reaches 1111 after 6 busy cycles; the re-pulsed start has no effect.
- start with steps=0 -> done pulse the next cycle, busy never high, q unchanged. With JOHNSON_WRAP_CNT_EN, steps=16 up from 0000 -> wraps=2.

Source files
------------

// File: rtl/johnson_step_ctrl.sv
// ============================================================================
// Module   : johnson_step_ctrl
// Brief    : Step sequencer and phase decoder for a twisted-ring (Johnson) counter.
//            Optional wrap counter output enabled by JOHNSON_WRAP_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module johnson_step_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               dir,
    input  logic [STEP_W-1:0]  steps,
    input  logic               hold,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic               busy,
    output logic               done,
`ifdef JOHNSON_WRAP_CNT_EN
    output logic [7:0]         wraps,
`endif
    output logic               err
);

    localparam int CNT_W = $clog2(2*WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [STEP_W-1:0]  r_rem;
    logic [STEP_W-1:0]  w_rem_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [WIDTH-1:0]   w_up;
    logic [WIDTH-1:0]   w_dn;
    logic [WIDTH-1:0]   w_step;
    logic               w_q_legal;
    logic               w_load_legal;
    logic [CNT_W-1:0]   w_pop;
    logic [CNT_W-1:0]   w_idx;

    // A Johnson code has at most one boundary between adjacent differing bits.
    function automatic logic is_johnson(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    assign w_up         = {~r_q[0], r_q[WIDTH-1:1]};
    assign w_dn         = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
    assign w_step       = r_dir ? w_dn : w_up;
    assign w_q_legal    = is_johnson(r_q);
    assign w_load_legal = is_johnson(load_val);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CNT_W'(r_q[i]);
        end
        w_idx = r_q[0] ? (CNT_W'(2*WIDTH) - w_pop) : w_pop;
    end

    assign phase = {{(2*WIDTH-1){1'b0}}, 1'b1} << w_idx;
    assign q     = r_q;
    assign err   = r_err;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    if (w_load_legal) begin
                        w_q_nxt = load_val;
                    end else begin
                        w_q_nxt   = '0;
                        w_err_nxt = 1'b1;
                    end
                end else if (start) begin
                    if (steps != '0) begin
                        w_dir_nxt   = dir;
                        w_rem_nxt   = steps;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!hold) begin
                    w_q_nxt   = w_step;
                    w_rem_nxt = r_rem - STEP_W'(1);
                    if (r_rem == STEP_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Corrupted ring recovers to zero regardless of state or hold.
        if (!w_q_legal) begin
            w_q_nxt   = '0;
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef JOHNSON_WRAP_CNT_EN
    logic [7:0] r_wraps;
    logic       w_wrap_clr;
    logic       w_wrap_inc;

    assign w_wrap_clr = (r_state == S_IDLE) && !load && start;
    assign w_wrap_inc = (r_state == S_RUN) && !hold && w_q_legal && (w_step == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wraps <= '0;
        end else if (w_wrap_clr) begin
            r_wraps <= '0;
        end else if (w_wrap_inc && (r_wraps != 8'hFF)) begin
            r_wraps <= r_wraps + 8'd1;
        end
    end

    assign wraps = r_wraps;
`endif

endmodule

`default_nettype wire

// File: tb/tb_johnson_step_ctrl.sv
// ============================================================================
// Module   : tb_johnson_step_ctrl
// Brief    : Directed plus randomized bench for johnson_step_ctrl against a phase-index model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_johnson_step_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic         start;
    logic         dir;
    logic [7:0]   steps;
    logic         hold;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic [2*W-1:0] phase;
    logic         busy;
    logic         done;
    logic         err;
`ifdef JOHNSON_WRAP_CNT_EN
    logic [7:0]   wraps;
`endif

    int   total = 0;
    int   bad   = 0;
    int   m_p   = 0;
    logic m_err = 1'b0;
    int   m_wraps = 0;

    johnson_step_ctrl #(.WIDTH(W), .STEP_W(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dir      (dir),
        .steps    (steps),
        .hold     (hold),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
`ifdef JOHNSON_WRAP_CNT_EN
        .wraps    (wraps),
`endif
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring code at phase index k: k leading ones for k<=W, else (2W-k) trailing ones.
    function automatic logic [W-1:0] code(input int k);
        if (k <= W) return W'(((1 << k) - 1) << (W - k));
        return W'((1 << (2*W - k)) - 1);
    endfunction

    function automatic int idx_of(input logic [W-1:0] v);
        for (int k = 0; k < 2*W; k++) begin
            if (code(k) == v) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input logic exp_busy, input logic exp_done);
        chk("q", 32'(q), 32'(code(m_p)));
        chk("phase", 32'(phase), 32'(1) << m_p);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(m_err));
`ifdef JOHNSON_WRAP_CNT_EN
        chk("wraps", 32'(wraps), 32'(m_wraps));
`endif
    endtask

    task automatic do_load(input logic [W-1:0] v);
        int k;
        load = 1'b1; load_val = v;
        start = 1'($urandom); steps = 8'($urandom); dir = 1'($urandom);
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        k = idx_of(v);
        if (k < 0) begin
            m_p = 0; m_err = 1'b1;
        end else begin
            m_p = k;
        end
        chk_outputs(1'b0, 1'b0);
    endtask

    task automatic do_run(input logic d, input int n, input logic [31:0] hmask);
        int a;
        int i;
        logic h;
        start = 1'b1; dir = d; steps = 8'(n); hold = 1'b0; load = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        m_wraps = 0;
        chk("accept_busy", 32'(busy), 32'(n != 0));
        chk("accept_done", 32'(done), 32'(n == 0));
        chk("accept_q", 32'(q), 32'(code(m_p)));
        a = 0; i = 0;
        while (a < n) begin
            h = (i < 32) ? hmask[i] : 1'b0;
            hold = h;
            start = h ? 1'b1 : 1'($urandom);
            load = 1'($urandom); dir = 1'($urandom);
            steps = 8'($urandom); load_val = W'($urandom);
            @(posedge clk); #1;
            if (!h) begin
                m_p = d ? (m_p + 2*W - 1) % (2*W) : (m_p + 1) % (2*W);
                a++;
                if (m_p == 0 && m_wraps < 255) m_wraps++;
            end
            i++;
            chk_outputs(a < n, a == n);
        end
        hold = 1'b0; start = 1'b0; load = 1'b0;
        @(posedge clk); #1;
        chk_outputs(1'b0, 1'b0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; dir = 1'b0; steps = '0;
        hold = 1'b0; load = 1'b0; load_val = '0;
        @(posedge clk); #1;
        chk_outputs(1'b0, 1'b0);
        clr = 1'b0;

        // Full up lap, then three steps down from zero.
        do_run(1'b0, 8, 32'h0);
        do_run(1'b1, 3, 32'h0);
        chk("down3_q", 32'(q), 32'h7);
        chk("down3_phase", 32'(phase), 32'h20);

        // Hold for two cycles after the first advance, start re-pulsed in RUN.
        do_load(4'b0000);
        do_run(1'b0, 4, 32'h6);
        chk("hold_q", 32'(q), 32'hF);

        do_run(1'b0, 0, 32'h0);

        do_load(4'b0101);
        do_load(4'b1100);

`ifdef JOHNSON_WRAP_CNT_EN
        do_load(4'b0000);
        do_run(1'b0, 16, 32'h0);
        chk("wraps16", 32'(wraps), 32'd2);
`endif

        // Asynchronous clear in the middle of a run.
        do_load(4'b1100);
        start = 1'b1; dir = 1'b0; steps = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("preclr_q", 32'(q), 32'hF);
        clr = 1'b1;
        #2;
        chk("aclr_q", 32'(q), 32'h0);
        chk("aclr_phase", 32'(phase), 32'h1);
        chk("aclr_busy", 32'(busy), 32'h0);
        chk("aclr_done", 32'(done), 32'h0);
        chk("aclr_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        clr = 1'b0;
        m_p = 0; m_err = 1'b0; m_wraps = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk_outputs(1'b0, 1'b0);
        end

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
            do_run(1'($urandom), int'($urandom_range(0, 20)), $urandom & $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
